// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - sequencing FSM for the shift-add signed multiplier datapath
module mult_ctrl #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = $clog2(N_BITS)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and iteration counter registers; Reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode; only Ld_XA/Sub look at the live multiplier bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = CLR;
        end else if (ClearA_LoadB) begin
          Clr_XA = 1'b1;
          Ld_B   = 1'b1;
        end
      end
      CLR: begin
        Clr_XA  = 1'b1;
        Busy    = 1'b1;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
        Ld_XA   = M;
        // The final partial product carries the multiplier's sign weight.
        Sub     = M && (cnt_q == LAST);
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
        // Waiting for Run release keeps a held switch from retriggering.
        if (!Run) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath strobes that would corrupt X:A:B if they overlapped.
  a_strobe_excl: assert property (@(posedge Clk) disable iff (Reset)
    !((Clr_XA && Ld_XA) || (Clr_XA && Shift_En) || (Ld_XA && Shift_En)));

  // A subtract request without a load would be silently dropped.
  a_sub_qual: assert property (@(posedge Clk) disable iff (Reset)
    (!Sub || Ld_XA));

endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - self-checking bench for mult_ctrl with a shift-add datapath model
module tb_mult_ctrl;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done;

  int checks   = 0;
  int failures = 0;

  logic       m_sel   = 1'b0;
  logic       m_const = 1'b0;
  logic [7:0] sw_b    = 8'h00;
  logic [7:0] sw_s    = 8'h00;
  logic       dp_x    = 1'b0;
  logic [7:0] dp_a    = 8'h00;
  logic [7:0] dp_b    = 8'h00;
  logic [8:0] dp_sum;
  logic [6:0] outs;
  logic       done_prev = 1'b0;
  logic [15:0] sb[$];

  always #5 Clk = ~Clk;

  mult_ctrl #(.N_BITS(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Ld_XA        (Ld_XA),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  assign M      = m_sel ? dp_b[0] : m_const;
  assign outs   = {Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done};
  assign dp_sum = Sub ? ({dp_a[7], dp_a} - {sw_s[7], sw_s})
                      : ({dp_a[7], dp_a} + {sw_s[7], sw_s});

  // Register/adder datapath driven by the controller strobes.
  always @(posedge Clk) begin
    if (Ld_B) dp_b <= sw_b;
    if (Clr_XA) begin
      dp_x <= 1'b0;
      dp_a <= 8'h00;
    end else if (Ld_XA) begin
      dp_x <= dp_sum[8];
      dp_a <= dp_sum[7:0];
    end else if (Shift_En) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each product is compared when Done rises.
  always @(negedge Clk) begin
    if (Done && !done_prev && sb.size() > 0) chk("product", {dp_a, dp_b}, sb.pop_front());
    done_prev = Done;
  end

  // Expected {Clr_XA,Ld_B,Ld_XA,Sub,Shift_En,Busy,Done} in cycle c after Run is taken.
  function automatic logic [6:0] expv(input int c, input logic [7:0] mb);
    logic clr, ldxa, sub, sh, busy, done;
    clr  = (c == 1);
    ldxa = (c >= 2) && (c <= 16) && (c % 2 == 0) && mb[(c - 2) / 2];
    sub  = ldxa && (c == 16);
    sh   = (c >= 3) && (c <= 17) && (c % 2 == 1);
    busy = (c >= 1) && (c <= 17);
    done = (c >= 18);
    return {clr, 1'b0, ldxa, sub, sh, busy, done};
  endfunction

  function automatic logic [15:0] mul(input logic [7:0] b, input logic [7:0] s);
    int p;
    p = $signed(b) * $signed(s);
    return p[15:0];
  endfunction

  task automatic step_idle();
    @(posedge Clk); #1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("idle", outs, 7'b0);
  endtask

  task automatic load_b(input logic [7:0] b, input logic [7:0] s);
    sw_b = b;
    sw_s = s;
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    chk("load_strobe", outs, 7'b1100000);
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("load_release", outs, 7'b0);
    chk("load_b_reg", {dp_x, dp_a, dp_b}, {9'h0, b});
  endtask

  task automatic run_op(input logic [7:0] mb, input int stop_cycle, input int clb_cycle,
                        input logic keep_run);
    Run = 1'b1;
    for (int c = 1; c <= stop_cycle; c++) begin
      @(posedge Clk); #1;
      Run = keep_run;
      ClearA_LoadB = (c == clb_cycle);
      @(negedge Clk);
      chk($sformatf("cycle%0d", c), outs, expv(c, mb));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Run = 1'b1;
    ClearA_LoadB = 1'b0;

    // Reset held two cycles with Run high, then Run launches a CLR.
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("reset_c1", outs, 7'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_c2", outs, 7'b0);
    @(posedge Clk); #1;
    Run = 1'b0;
    @(negedge Clk);
    chk("clr_after_reset", outs, 7'b1000010);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_in_clr", outs, 7'b0);
    step_idle();

    // Button load in IDLE.
    load_b(8'h3C, 8'h11);

    // Constant M=1, then constant M=0.
    m_const = 1'b1;
    run_op(8'hFF, 18, 0, 1'b0);
    step_idle();
    m_const = 1'b0;
    run_op(8'h00, 18, 0, 1'b0);
    step_idle();

    // Closed loop: 7 * -3.
    m_sel = 1'b1;
    load_b(8'h07, 8'hFD);
    sb.push_back(16'hFFEB);
    run_op(8'h07, 18, 0, 1'b0);
    step_idle();

    // Run held through DONE, then release, then a second product.
    load_b(8'h80, 8'h80);
    sb.push_back(mul(8'h80, 8'h80));
    run_op(8'h80, 40, 0, 1'b1);
    @(posedge Clk); #1;
    Run = 1'b0;
    @(negedge Clk);
    chk("done_last_cycle", outs, 7'b0000001);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("idle_after_release", outs, 7'b0);
    load_b(8'hB9, 8'h2B);
    sb.push_back(mul(8'hB9, 8'h2B));
    run_op(8'hB9, 18, 0, 1'b0);
    step_idle();

    // Reset during SHIFT_3 aborts without further strobes.
    load_b(8'h5A, 8'h13);
    run_op(8'h5A, 9, 0, 1'b0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("after_mid_reset", outs, 7'b0);
    step_idle();

    // ClearA_LoadB during ADD_2 is ignored and the product survives.
    load_b(8'h5A, 8'h13);
    sw_b = 8'hFF;
    sb.push_back(mul(8'h5A, 8'h13));
    run_op(8'h5A, 18, 6, 1'b0);
    step_idle();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
